// File: rtl/aes_batch_loader.sv
// aes_batch_loader
//   Collects plaintext/key words into a batch of N 128-bit lanes, launches a
//   parallel AES engine with a one-cycle start pulse, captures the engine's
//   lane-packed result on done and streams the active lanes back out.
//
//   Handshakes: a word moves on any rising edge where valid and ready are
//   both 1. in_ready is high only in FILL (and low while rstn=0). out_valid
//   is high only in DRAIN; out_data/out_last hold until out_ready accepts.
//
// Ports
//   clk, rstn             clock, asynchronous active-low reset
//   in_valid/in_ready     input word handshake
//   in_text, in_key       plaintext block and its key
//   in_flush              launch a partial batch with the words filled so far
//   plain_text, cipher_key lane-packed engine inputs, lane i at [128*i +: 128]
//   start                 one-cycle engine launch pulse
//   done, cipher_text     engine completion pulse and lane-packed result
//   out_valid/out_ready   result word handshake
//   out_data, out_last    result word, last-word-of-batch marker
//   batch_count           completed (fully drained) batches, wraps at 16 bits
//   busy                  high in any state other than FILL
//   state                 current FSM state (0 FILL, 1 LAUNCH, 2 WAIT, 3 DRAIN)
module aes_batch_loader #(
  parameter int N = 10
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [127:0]       in_text,
  input  logic [127:0]       in_key,
  input  logic               in_flush,
  output logic [128*N-1:0]   plain_text,
  output logic [128*N-1:0]   cipher_key,
  output logic               start,
  input  logic               done,
  input  logic [128*N-1:0]   cipher_text,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [127:0]       out_data,
  output logic               out_last,
  output logic [15:0]        batch_count,
  output logic               busy,
  output logic [1:0]         state
);

  // Wide enough to hold the value N itself (active lane count of a full batch).
  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {
    FILL   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2,
    DRAIN  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     fill_cnt;
  logic [CW-1:0]     rd_idx;
  logic [CW-1:0]     k_q;
  logic [128*N-1:0]  cap_q;

  logic              accept;
  logic [CW-1:0]     cnt_after;
  logic              full_go;
  logic              flush_go;
  logic              hs;
  logic              at_last;

  // Flush is evaluated against the count after a same-cycle accept; a word
  // that completes the batch takes priority and makes it a normal full batch.
  always_comb begin
    accept    = (state_q == FILL) && in_valid;
    cnt_after = accept ? fill_cnt + 1'b1 : fill_cnt;
    full_go   = accept && (fill_cnt == CW'(N - 1));
    flush_go  = (state_q == FILL) && in_flush && !full_go && (cnt_after != '0);
    hs        = (state_q == DRAIN) && out_ready;
    at_last   = (rd_idx == k_q - 1'b1);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= FILL;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      FILL:    if (full_go || flush_go) state_d = LAUNCH;
      LAUNCH:  state_d = WAIT;
      WAIT:    if (done) state_d = DRAIN;
      DRAIN:   if (hs && at_last) state_d = FILL;
      default: state_d = FILL;
    endcase
  end

  always_comb begin
    in_ready  = rstn && (state_q == FILL);
    start     = (state_q == LAUNCH);
    out_valid = (state_q == DRAIN);
    out_last  = (state_q == DRAIN) && at_last;
    busy      = (state_q != FILL);
    state     = state_q;
    out_data  = '0;
    for (int i = 0; i < N; i++) begin
      if (rd_idx == CW'(i)) out_data = cap_q[128*i +: 128];
    end
  end

  // Lanes are only written in FILL, so they hold from LAUNCH until the batch
  // has drained. A flush zeroes every lane from the updated count upward so
  // stale words from an earlier batch never reach the engine.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      plain_text  <= '0;
      cipher_key  <= '0;
      fill_cnt    <= '0;
      k_q         <= '0;
      rd_idx      <= '0;
      cap_q       <= '0;
      batch_count <= '0;
    end else begin
      if (state_q == FILL) begin
        fill_cnt <= cnt_after;
        for (int i = 0; i < N; i++) begin
          if (accept && (fill_cnt == CW'(i))) begin
            plain_text[128*i +: 128] <= in_text;
            cipher_key[128*i +: 128] <= in_key;
          end else if (flush_go && (CW'(i) >= cnt_after)) begin
            plain_text[128*i +: 128] <= '0;
            cipher_key[128*i +: 128] <= '0;
          end
        end
        if (full_go)       k_q <= CW'(N);
        else if (flush_go) k_q <= cnt_after;
      end

      if ((state_q == WAIT) && done) begin
        cap_q  <= cipher_text;
        rd_idx <= '0;
      end

      if (hs) begin
        rd_idx <= rd_idx + 1'b1;
        if (at_last) begin
          batch_count <= batch_count + 16'd1;
          fill_cnt    <= '0;
        end
      end
    end
  end

endmodule
